multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main controller: Moore FSM that sequences
// fetch, decode and per-instruction execute/writeback steps.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] op,
   input  logic       zero,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       illegal,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JUMP    = 4'd11
   } state_e;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_e state_q, state_d;
   logic   pcwrite, branch;
   logic   irwrite_s, memwrite_s, regwrite_s, illegal_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= FETCH;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = FETCH;
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      illegal_s  = 1'b0;
      case (state_q)
         FETCH: begin
            state_d   = DECODE;
            alusrcb   = 2'b01;
            irwrite_s = 1'b1;
            pcwrite   = 1'b1;
         end
         DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYP:      state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JUMP;
               default: begin
                  state_d   = FETCH;
                  illegal_s = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            state_d = (op == OP_LW) ? MEMRD : MEMWR;
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD: begin
            state_d = MEMWB;
            iord    = 1'b1;
         end
         MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
         end
         EXECUTE: begin
            state_d = ALUWB;
            alusrca = 1'b1;
            aluop   = 2'b10;
         end
         ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         BRANCH: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         ADDIEX: begin
            state_d = ADDIWB;
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         ADDIWB: regwrite_s = 1'b1;
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // Enables are gated by reset so nothing writes while reset is held.
   assign irwrite  = irwrite_s & reset_n;
   assign memwrite = memwrite_s & reset_n;
   assign regwrite = regwrite_s & reset_n;
   assign illegal  = illegal_s & reset_n;
   assign pcen     = (pcwrite | (branch & zero)) & reset_n;
   assign state_o  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class
// through its state sequence and checks state and all outputs.
module tb_multicycle_ctrl;

   logic       clk;
   logic       reset_n;
   logic [5:0] op;
   logic       zero;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite;
   logic       alusrca, pcen, illegal;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   multicycle_ctrl dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op       (op),
      .zero     (zero),
      .iord     (iord),
      .memwrite (memwrite),
      .irwrite  (irwrite),
      .regdst   (regdst),
      .memtoreg (memtoreg),
      .regwrite (regwrite),
      .alusrca  (alusrca),
      .alusrcb  (alusrcb),
      .aluop    (aluop),
      .pcsrc    (pcsrc),
      .pcen     (pcen),
      .illegal  (illegal),
      .state_o  (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
   //  alusrcb,aluop,pcsrc,pcen,illegal}
   localparam logic [14:0] V_FETCH = 15'b0010000_01_00_00_1_0;
   localparam logic [14:0] V_RST   = 15'b0000000_01_00_00_0_0;
   localparam logic [14:0] V_DEC   = 15'b0000000_11_00_00_0_0;
   localparam logic [14:0] V_ILL   = 15'b0000000_11_00_00_0_1;
   localparam logic [14:0] V_MADR  = 15'b0000001_10_00_00_0_0;
   localparam logic [14:0] V_MRD   = 15'b1000000_00_00_00_0_0;
   localparam logic [14:0] V_MWB   = 15'b0000110_00_00_00_0_0;
   localparam logic [14:0] V_MWR   = 15'b1100000_00_00_00_0_0;
   localparam logic [14:0] V_EXE   = 15'b0000001_00_10_00_0_0;
   localparam logic [14:0] V_AWB   = 15'b0001010_00_00_00_0_0;
   localparam logic [14:0] V_BRT   = 15'b0000001_00_01_01_1_0;
   localparam logic [14:0] V_BRN   = 15'b0000001_00_01_01_0_0;
   localparam logic [14:0] V_IWB   = 15'b0000010_00_00_00_0_0;
   localparam logic [14:0] V_JMP   = 15'b0000000_00_00_10_1_0;

   function automatic logic [14:0] outs();
      return {iord, memwrite, irwrite, regdst, memtoreg, regwrite,
              alusrca, alusrcb, aluop, pcsrc, pcen, illegal};
   endfunction

   task automatic chk(input string tag, input logic [3:0] st,
                      input logic [14:0] ov);
      checks++;
      assert (state_o === st) else begin
         errors++;
         $error("FAIL %s state got %0d expected %0d", tag, state_o, st);
      end
      checks++;
      assert (outs() === ov) else begin
         errors++;
         $error("FAIL %s outs got %b expected %b", tag, outs(), ov);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      op      = 6'b000000;
      zero    = 1'b0;
      #2;
      chk("rst", 4'd0, V_RST);
      @(posedge clk);
      #1;
      chk("rst_hold", 4'd0, V_RST);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("fetch0", 4'd0, V_FETCH);

      // lw: 0,1,2,3,4,0
      op = 6'b100011;
      step(); chk("lw_dec", 4'd1, V_DEC);
      step(); chk("lw_madr", 4'd2, V_MADR);
      step(); chk("lw_mrd", 4'd3, V_MRD);
      step(); chk("lw_mwb", 4'd4, V_MWB);
      step(); chk("lw_fetch", 4'd0, V_FETCH);

      // sw: 0,1,2,5,0 with zero high outside BRANCH
      op = 6'b101011;
      step(); chk("sw_dec", 4'd1, V_DEC);
      step(); chk("sw_madr", 4'd2, V_MADR);
      zero = 1'b1;
      step(); chk("sw_mwr", 4'd5, V_MWR);
      zero = 1'b0;
      step(); chk("sw_fetch", 4'd0, V_FETCH);

      // R-type
      op = 6'b000000;
      step(); chk("r_dec", 4'd1, V_DEC);
      step(); chk("r_exe", 4'd6, V_EXE);
      step(); chk("r_awb", 4'd7, V_AWB);
      step(); chk("r_fetch", 4'd0, V_FETCH);

      // addi
      op = 6'b001000;
      step(); chk("addi_dec", 4'd1, V_DEC);
      step(); chk("addi_ex", 4'd9, V_MADR);
      step(); chk("addi_wb", 4'd10, V_IWB);
      step(); chk("addi_fetch", 4'd0, V_FETCH);

      // beq taken, then zero dropped mid-cycle
      op   = 6'b000100;
      zero = 1'b1;
      step(); chk("beqt_dec", 4'd1, V_DEC);
      step(); chk("beqt_br", 4'd8, V_BRT);
      zero = 1'b0;
      #1;
      chk("beqt_br_z0", 4'd8, V_BRN);
      step(); chk("beqt_fetch", 4'd0, V_FETCH);

      // beq not taken
      step(); chk("beqn_dec", 4'd1, V_DEC);
      step(); chk("beqn_br", 4'd8, V_BRN);
      step(); chk("beqn_fetch", 4'd0, V_FETCH);

      // j
      op = 6'b000010;
      step(); chk("j_dec", 4'd1, V_DEC);
      step(); chk("j_jmp", 4'd11, V_JMP);
      step(); chk("j_fetch", 4'd0, V_FETCH);

      // illegal opcode
      op = 6'b111111;
      step(); chk("ill_dec", 4'd1, V_ILL);
      step(); chk("ill_fetch", 4'd0, V_FETCH);

      // reset dropped in MEMWR
      op = 6'b101011;
      step(); chk("rsw_dec", 4'd1, V_DEC);
      step(); chk("rsw_madr", 4'd2, V_MADR);
      step(); chk("rsw_mwr", 4'd5, V_MWR);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rsw_async", 4'd0, V_RST);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rsw_rel", 4'd0, V_FETCH);
      step(); chk("rsw_dec2", 4'd1, V_DEC);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
